// File: rtl/addern_pkg.sv
// Elaboration-time helpers shared by the segmented pipelined adder/subtractor.
package addern_pkg;

   function automatic bit stages_ok(input int unsigned n, input int unsigned stages);
      return (stages != 0) && ((n % stages) == 0);
   endfunction

   function automatic int unsigned seg_width(input int unsigned n, input int unsigned stages);
      return (stages == 0) ? n : n / stages;
   endfunction

endpackage

// File: rtl/addern_seg.sv
// Combinational W-bit ripple segment; exposes carry into its MSB for overflow detection.
module addern_seg #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         c_i,
   output logic [W-1:0] sum_o,
   output logic         co_o,
   output logic         cmsb_o
);

   logic [W:0] carry;

   always_comb begin
      carry    = '0;
      sum_o    = '0;
      carry[0] = c_i;
      for (int unsigned i = 0; i < W; i++) begin
         sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
         carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
      end
   end

   assign co_o   = carry[W];
   assign cmsb_o = carry[W-1];

endmodule

// File: rtl/addern_pipe.sv
// Pipelined ripple-carry adder/subtractor: one W-bit segment per stage, skewed operands in,
// deskewed sum out, single global advance for valid/ready flow control.
module addern_pipe
   import addern_pkg::*;
#(
   parameter int unsigned N      = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         sub,
   input  logic         carryin,
   input  logic [N-1:0] X,
   input  logic [N-1:0] Y,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] S,
   output logic         carryout,
   output logic         overflow
);

   localparam int unsigned W = seg_width(N, STAGES);

   if (!stages_ok(N, STAGES)) begin : g_cfg_err
      $error("addern_pipe: STAGES must be non-zero and divide N exactly");
   end

   logic                      adv;
   logic [N-1:0]              y_eff;
   logic                      cin_eff;
   logic [STAGES-1:0][W-1:0]  seg_a, seg_b, seg_sum;
   logic [STAGES-1:0]         seg_c, seg_co, seg_cm;
   logic [STAGES-1:0][N-1:0]  x_q, x_d, y_q, y_d, s_q, s_d;
   logic [STAGES-1:0]         c_q, c_d, v_q, v_d;
   logic                      cmsb_q, cmsb_d;
   logic                      unused_skew;

   // Subtraction as X + ~Y + ~borrow, resolved once before the first segment.
   assign y_eff   = sub ? ~Y : Y;
   assign cin_eff = sub ? ~carryin : carryin;

   assign adv       = out_ready | ~v_q[STAGES-1];
   assign in_ready  = adv;
   assign out_valid = v_q[STAGES-1];
   assign S         = s_q[STAGES-1];
   assign carryout  = c_q[STAGES-1];
   assign overflow  = cmsb_q ^ c_q[STAGES-1];

   always_comb begin
      seg_a    = '0;
      seg_b    = '0;
      seg_c    = '0;
      seg_a[0] = X[W-1:0];
      seg_b[0] = y_eff[W-1:0];
      seg_c[0] = cin_eff;
      for (int unsigned k = 1; k < STAGES; k++) begin
         seg_a[k] = x_q[k-1][k*W +: W];
         seg_b[k] = y_q[k-1][k*W +: W];
         seg_c[k] = c_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_seg
      addern_seg #(.W(W)) u_seg (
         .a_i    (seg_a[k]),
         .b_i    (seg_b[k]),
         .c_i    (seg_c[k]),
         .sum_o  (seg_sum[k]),
         .co_o   (seg_co[k]),
         .cmsb_o (seg_cm[k])
      );
   end

   // Each stage forwards operands (skew) and partial sum (deskew), patching in its own segment.
   always_comb begin
      x_d           = '0;
      y_d           = '0;
      s_d           = '0;
      c_d           = '0;
      v_d           = '0;
      x_d[0]        = X;
      y_d[0]        = y_eff;
      s_d[0][W-1:0] = seg_sum[0];
      c_d[0]        = seg_co[0];
      v_d[0]        = in_valid;
      for (int unsigned k = 1; k < STAGES; k++) begin
         x_d[k]            = x_q[k-1];
         y_d[k]            = y_q[k-1];
         s_d[k]            = s_q[k-1];
         s_d[k][k*W +: W]  = seg_sum[k];
         c_d[k]            = seg_co[k];
         v_d[k]            = v_q[k-1];
      end
      cmsb_d = seg_cm[STAGES-1];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         x_q    <= '0;
         y_q    <= '0;
         s_q    <= '0;
         c_q    <= '0;
         v_q    <= '0;
         cmsb_q <= '0;
      end else if (adv) begin
         x_q    <= x_d;
         y_q    <= y_d;
         s_q    <= s_d;
         c_q    <= c_d;
         v_q    <= v_d;
         cmsb_q <= cmsb_d;
      end
   end

   // Already-consumed skew bits and inner-segment MSB carries are intentionally dropped.
   assign unused_skew = ^{x_q, y_q, seg_cm};

endmodule

// File: tb/tb_addern_pipe.sv
// Directed and randomized checks of addern_pipe in four configurations against an arithmetic model.
module tb_addern_pipe;

   logic        clk;
   logic        rst;
   logic        iv   [4];
   logic        ir   [4];
   logic        sb   [4];
   logic        ci   [4];
   logic [31:0] xx   [4];
   logic [31:0] yy   [4];
   logic        ovld [4];
   logic        ordy [4];
   logic [31:0] ss   [4];
   logic        co   [4];
   logic        of   [4];
   logic [11:0] s3;

   int          checks;
   int          errors;
   int          nb [4];
   logic [33:0] expq [4][$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   addern_pipe #(.N(32), .STAGES(4)) u_d0 (
      .clock(clk), .reset(rst), .in_valid(iv[0]), .in_ready(ir[0]), .sub(sb[0]), .carryin(ci[0]),
      .X(xx[0]), .Y(yy[0]), .out_valid(ovld[0]), .out_ready(ordy[0]), .S(ss[0]),
      .carryout(co[0]), .overflow(of[0]));
   addern_pipe #(.N(32), .STAGES(1)) u_d1 (
      .clock(clk), .reset(rst), .in_valid(iv[1]), .in_ready(ir[1]), .sub(sb[1]), .carryin(ci[1]),
      .X(xx[1]), .Y(yy[1]), .out_valid(ovld[1]), .out_ready(ordy[1]), .S(ss[1]),
      .carryout(co[1]), .overflow(of[1]));
   addern_pipe #(.N(32), .STAGES(32)) u_d2 (
      .clock(clk), .reset(rst), .in_valid(iv[2]), .in_ready(ir[2]), .sub(sb[2]), .carryin(ci[2]),
      .X(xx[2]), .Y(yy[2]), .out_valid(ovld[2]), .out_ready(ordy[2]), .S(ss[2]),
      .carryout(co[2]), .overflow(of[2]));
   addern_pipe #(.N(12), .STAGES(3)) u_d3 (
      .clock(clk), .reset(rst), .in_valid(iv[3]), .in_ready(ir[3]), .sub(sb[3]), .carryin(ci[3]),
      .X(xx[3][11:0]), .Y(yy[3][11:0]), .out_valid(ovld[3]), .out_ready(ordy[3]), .S(s3),
      .carryout(co[3]), .overflow(of[3]));

   assign ss[3] = {20'h0, s3};

   // Reference: exact integer arithmetic, result packed as {overflow, carryout, S}.
   function automatic logic [33:0] model(input int n, input bit sub_, input bit cin_,
                                         input logic [31:0] x, input logic [31:0] y);
      longint m, ux, uy, sx, sy, ur, sr;
      bit     c, o;
      m  = longint'(1) << n;
      ux = longint'(x) & (m - 1);
      uy = longint'(y) & (m - 1);
      sx = (ux >= m / 2) ? ux - m : ux;
      sy = (uy >= m / 2) ? uy - m : uy;
      if (!sub_) begin
         ur = ux + uy + longint'(cin_);
         sr = sx + sy + longint'(cin_);
         c  = (ur >= m);
      end else begin
         ur = ux - uy - longint'(cin_);
         sr = sx - sy - longint'(cin_);
         c  = (ur >= 0);
      end
      o = (sr >= m / 2) || (sr < -(m / 2));
      return {o, c, 32'(ur & (m - 1))};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run0(input string tag, input bit s_, input bit c_,
                       input logic [31:0] x, input logic [31:0] y, input logic [33:0] exp);
      int lat;
      @(negedge clk);
      iv[0] = 1'b1; sb[0] = s_; ci[0] = c_; xx[0] = x; yy[0] = y; ordy[0] = 1'b1;
      #1 check({tag, "_ready"}, 64'(ir[0]), 64'd1);
      @(negedge clk);
      iv[0] = 1'b0;
      lat = 1;
      while (!ovld[0] && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'd4);
      check({tag, "_result"}, 64'({of[0], co[0], ss[0]}), 64'(exp));
   endtask

   logic [31:0] b4x [8];
   logic [31:0] b4y [8];
   bit          b4s [8];
   bit          b4c [8];
   logic [33:0] e4  [8];
   int          sent, got, stall_left, extra;
   bit          stalled;
   int          rsent [4];
   int          rgot  [4];
   logic [33:0] e;

   initial begin
      checks = 0;
      errors = 0;
      nb[0] = 32; nb[1] = 32; nb[2] = 32; nb[3] = 12;
      rst = 1'b1;
      for (int d = 0; d < 4; d++) begin
         iv[d] = 1'b0; sb[d] = 1'b0; ci[d] = 1'b0; xx[d] = '0; yy[d] = '0; ordy[d] = 1'b1;
      end

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_in_ready", 64'(ir[0]), 64'd1);
      check("rst_out_valid", 64'(ovld[0]), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("post_rst_outputs", 64'({ovld[0], of[0], co[0], ss[0]}), 64'd0);
      check("post_rst_in_ready", 64'(ir[0]), 64'd1);

      // Directed arithmetic on the 32/4 configuration
      run0("add_wrap", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, {1'b0, 1'b1, 32'h0000_0000});
      run0("add_ovf",  1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, {1'b1, 1'b0, 32'h8000_0000});
      run0("sub_borrow", 1'b1, 1'b0, 32'd5, 32'd7, {1'b0, 1'b0, 32'hFFFF_FFFE});
      run0("sub_bin",  1'b1, 1'b1, 32'd7, 32'd5, {1'b0, 1'b1, 32'h0000_0001});
      run0("add_cin",  1'b0, 1'b1, 32'h1234_5678, 32'h1111_1111, {1'b0, 1'b0, 32'h2345_678A});
      run0("sub_ovf",  1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, {1'b1, 1'b1, 32'h7FFF_FFFF});

      // Eight back-to-back beats with a 3-cycle output stall after the first result
      for (int i = 0; i < 8; i++) begin
         b4x[i] = 32'h2345_6789 * i + 32'hF0F0_0000;
         b4y[i] = 32'hFFFF_FFFF - 32'(i * 3);
         b4s[i] = i[0];
         b4c[i] = i[1];
         e4[i]  = model(32, b4s[i], b4c[i], b4x[i], b4y[i]);
      end
      sent = 0; got = 0; stall_left = 0; stalled = 1'b0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         @(negedge clk);
         if (ovld[0] && !stalled) begin
            stalled = 1'b1;
            stall_left = 3;
         end
         ordy[0] = (stall_left == 0);
         iv[0]   = (sent < 8);
         if (sent < 8) begin
            xx[0] = b4x[sent]; yy[0] = b4y[sent]; sb[0] = b4s[sent]; ci[0] = b4c[sent];
         end
         #1;
         if (stall_left > 0) begin
            check("stall_in_ready", 64'(ir[0]), 64'd0);
            check("stall_hold", 64'({ovld[0], of[0], co[0], ss[0]}), 64'({1'b1, e4[got]}));
            stall_left--;
         end
         if (iv[0] && ir[0]) sent++;
         if (ovld[0] && ordy[0]) begin
            check($sformatf("b2b_beat%0d", got), 64'({of[0], co[0], ss[0]}), 64'(e4[got]));
            got++;
         end
      end
      iv[0] = 1'b0; ordy[0] = 1'b1;
      check("b2b_count", 64'(got), 64'd8);
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         #1 if (ovld[0]) extra++;
      end
      check("b2b_no_dup", 64'(extra), 64'd0);

      // Reset with three beats in flight
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         iv[0] = 1'b1; sb[0] = 1'b0; ci[0] = 1'b0;
         xx[0] = 32'h1000_0000 * (i + 1); yy[0] = 32'd1;
      end
      @(negedge clk);
      iv[0] = 1'b0;
      rst   = 1'b1;
      #1 check("midrst_in_ready", 64'(ir[0]), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      #1 check("midrst_flush", 64'({ovld[0], of[0], co[0], ss[0]}), 64'd0);
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         #1 if (ovld[0]) extra++;
      end
      check("midrst_no_ghost", 64'(extra), 64'd0);
      run0("post_midrst", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 1'b1, 32'hFFFF_FFFE});

      // Randomized traffic on all four configurations with random backpressure
      for (int d = 0; d < 4; d++) begin
         rsent[d] = 0;
         rgot[d]  = 0;
      end
      for (int cyc = 0; cyc < 20000 &&
           !(rgot[0] >= 1000 && rgot[1] >= 1000 && rgot[2] >= 1000 && rgot[3] >= 1000); cyc++) begin
         @(negedge clk);
         for (int d = 0; d < 4; d++) begin
            ordy[d] = ($urandom_range(0, 3) != 0);
            iv[d]   = (rsent[d] < 1000) && ($urandom_range(0, 3) != 0);
            sb[d]   = 1'($urandom_range(0, 1));
            ci[d]   = 1'($urandom_range(0, 1));
            xx[d]   = $urandom;
            yy[d]   = $urandom;
            if ($urandom_range(0, 7) == 0) begin
               xx[d] = '1;
               yy[d] = 32'd1;
            end
         end
         #1;
         for (int d = 0; d < 4; d++) begin
            if (iv[d] && ir[d]) begin
               expq[d].push_back(model(nb[d], sb[d], ci[d], xx[d], yy[d]));
               rsent[d]++;
            end
            if (ovld[d] && ordy[d]) begin
               if (expq[d].size() == 0) begin
                  check($sformatf("rnd_d%0d_unexpected", d), 64'd1, 64'd0);
               end else begin
                  e = expq[d].pop_front();
                  check($sformatf("rnd_d%0d_beat%0d", d, rgot[d]),
                        64'({of[d], co[d], ss[d]}), 64'(e));
               end
               rgot[d]++;
            end
         end
      end
      for (int d = 0; d < 4; d++) begin
         iv[d] = 1'b0;
         check($sformatf("rnd_d%0d_count", d), 64'(rgot[d]), 64'd1000);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/addern_pipe.md
Name: addern_pipe

Overview:
Parametrised pipelined ripple-carry adder/subtractor, the registered successor to the combinational n-bit adder.
- N-bit operands are split into STAGES equal segments; stage k ripples segment k using the registered carry from stage k-1.
- Adds subtract mode, signed-overflow detection and valid/ready flow control, so long adders close timing in the datapath.

Parameters:
N, 32, operand/result width in bits
STAGES, 4, pipeline depth and segment count; must divide N exactly, otherwise elaboration fails. Segment width W = N/STAGES.

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts a beat this cycle
sub  input  1  0: S = X + Y + carryin; 1: S = X - Y - carryin (carryin acts as borrow-in)
carryin  input  1  carry-in / borrow-in
X  input  N  operand A
Y  input  N  operand B
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
S  output  N  sum/difference
carryout  output  1  carry out of bit N-1; in subtract mode 1 means no borrow
overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Subtract is implemented as X + ~Y + ~carryin. Y inversion and carry-in selection happen in stage 0 only.
- Global advance signal: adv = out_ready | ~out_valid.
  - in_ready = adv, combinational; no dependence on in_valid.
  - All pipeline registers load only when adv=1.
- Bubbles occupy slots; they do not collapse.
- Beat accepted when in_valid & in_ready.
- Per-stage valid bit v[k]: v[0] <= in_valid when adv; v[k] <= v[k-1] when adv. out_valid = v[STAGES-1].
- Stage k, for k = 0..STAGES-1:
  - adds segment k of the operands (W bits) plus the carry registered by stage k-1 (stage 0 uses the effective carry-in);
  - registers the W-bit sum segment and the carry out.
- Skew registers carry the not-yet-added upper operand segments forward.
- Deskew registers carry the completed lower sum segments forward, so S is fully aligned at the output.
- Latency: a beat accepted in cycle t appears on out_valid/S in cycle t+STAGES when no stall occurs. Throughput is 1 beat per cycle.
- The final stage also registers the carry into bit N-1 and the carry out of bit N-1; overflow is derived from these two.
- Stall (out_valid=1, out_ready=0): S, carryout, overflow and every internal register hold exactly. in_ready=0. No beat is lost or duplicated.
- Results leave in acceptance order. Operands presented while in_ready=0 are ignored.
- Reset, including mid-operation:
  - all v[k] are 0 on the next edge, so out_valid=0 and every in-flight beat is discarded;
  - S, carryout, overflow and all data registers reset to 0;
  - in_ready=1 during and after reset.
- STAGES=1: a single registered ripple adder with latency 1.
- STAGES=N: W=1 (bit-serial style pipeline) with latency N.
- Carry propagation across all segments (e.g. all-ones + 1) must be correct with no extra cycles.

Decomposition:
- Package addern_pkg: nothing beyond an elaboration-time check function (N % STAGES == 0) and a localparam W helper. No typedefs needed.
- One natural sub-module, addern_seg:
  - combinational W-bit ripple segment with carry-in;
  - outputs sum, carry-out and carry into its MSB;
  - instantiated STAGES times via generate.
- The top level holds the valid chain, skew/deskew registers and flow control.

Test Plan:
1. N=32, STAGES=4, add, X=0xFFFFFFFF, Y=0x00000001, carryin=0 -> at t+4: S=0x00000000, carryout=1, overflow=0.
2. Add, X=0x7FFFFFFF, Y=0x00000001, carryin=0 -> S=0x80000000, carryout=0, overflow=1.
3. sub=1, X=5, Y=7, carryin=0 -> S=0xFFFFFFFE, carryout=0 (borrow), overflow=0. Then sub=1, X=7, Y=5, carryin=1 -> S=0x00000001, carryout=1.
4. Eight back-to-back beats; out_ready=0 for 3 cycles after the first result -> S held constant, in_ready=0, all 8 results emerge in order, none lost or duplicated.
5. reset asserted for 1 cycle with 3 beats in flight -> out_valid=0 on the following cycle, none of the 3 beats ever emerge, next accepted beat appears 4 cycles after acceptance.
6. Configurations (N=32, STAGES=1), (N=32, STAGES=32) and (N=12, STAGES=3), each with 1000 random beats, random sub/carryin and random out_ready -> all match the reference model for S, carryout and overflow.
